// File: rtl/uart_8n1_tx_scheduler.sv
// Round-robin scheduler sharing one UART 8N1 transmitter among N requesters, with baud-change sequencing.
// Optional build macro UART_8N1_TX_SCHED_LOCK_EN adds req_lock to let the last granted lane keep the transmitter.
module uart_8n1_tx_scheduler #(
    parameter int N                = 4,
    parameter int GEN_RESET_CYCLES = 2
) (
    input  logic                 clk_src,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [8*N-1:0]       req_data,
`ifdef UART_8N1_TX_SCHED_LOCK_EN
    input  logic [N-1:0]         req_lock,
`endif
    output logic [N-1:0]         req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    input  logic [1:0]           cfg_baud_rate,
    input  logic                 cfg_update,
    output logic [1:0]           baud_rate,
    output logic                 clk_gen_reset,
    output logic                 cfg_pending,
    output logic [$clog2(N)-1:0] grant
);
    localparam logic [1:0] UART_8N1_BAUD_9600   = 2'd0;
    localparam logic [1:0] UART_8N1_BAUD_19200  = 2'd1;
    localparam logic [1:0] UART_8N1_BAUD_38400  = 2'd2;
    localparam logic [1:0] UART_8N1_BAUD_115200 = 2'd3;
    localparam int GW = $clog2(N);
    localparam int CW = $clog2(GEN_RESET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, DRAIN, RECONF} state_t;

    state_t          state;
    state_t          state_next;
    logic            busy_m;
    logic            busy_s;
    logic [1:0]      cfg_next;
    logic [CW-1:0]   gen_cnt;
    logic            found;
    logic            accept;
    logic            enter_reconf;
    logic [GW-1:0]   sel;
    logic [GW-1:0]   idx;

    always_ff @(posedge clk_src) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Arbitration and next-state: reconfiguration outranks data in IDLE.
    always_comb begin
        found        = 1'b0;
        sel          = grant;
        idx          = grant;
        state_next   = state;
        accept       = 1'b0;
        enter_reconf = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(grant) + k) % N);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
`ifdef UART_8N1_TX_SCHED_LOCK_EN
        if (req_lock[grant] && req_valid[grant]) begin
            found = 1'b1;
            sel   = grant;
        end
`endif
        case (state)
            IDLE: begin
                if (cfg_pending) begin
                    enter_reconf = 1'b1;
                    state_next   = RECONF;
                end else if (found) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START:   if (busy_s)         state_next = DRAIN;
            DRAIN:   if (!busy_s)        state_next = IDLE;
            RECONF:  if (gen_cnt == '0)  state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_src) begin
        if (reset) begin
            busy_m        <= 1'b0;
            busy_s        <= 1'b0;
            req_ready     <= '0;
            tx_data       <= 8'h00;
            tx_start      <= 1'b0;
            baud_rate     <= UART_8N1_BAUD_9600;
            cfg_next      <= UART_8N1_BAUD_9600;
            cfg_pending   <= 1'b0;
            clk_gen_reset <= 1'b0;
            gen_cnt       <= '0;
            grant         <= GW'(N - 1);
        end else begin
            busy_m    <= tx_busy;
            busy_s    <= busy_m;
            req_ready <= '0;
            // tx_start is registered off the START state so it rises one edge after acceptance.
            tx_start  <= (state == START) && !busy_s;
            if (accept) begin
                req_ready <= N'(1) << sel;
                tx_data   <= req_data[8*sel +: 8];
                grant     <= sel;
            end
            // A fresh strobe beats the clear on RECONF entry, so it schedules another RECONF.
            if (cfg_update) begin
                cfg_next    <= cfg_baud_rate;
                cfg_pending <= 1'b1;
            end else if (enter_reconf) begin
                cfg_pending <= 1'b0;
            end
            if (enter_reconf) begin
                baud_rate     <= cfg_next;
                clk_gen_reset <= 1'b1;
                gen_cnt       <= CW'(GEN_RESET_CYCLES - 1);
            end else if (state == RECONF) begin
                if (gen_cnt == '0) clk_gen_reset <= 1'b0;
                else               gen_cnt       <= gen_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_8n1_tx_scheduler.sv
// Scoreboard bench for uart_8n1_tx_scheduler: stimulus queues expected grants, a monitor checks each req_ready pulse.
module tb_uart_8n1_tx_scheduler;
    localparam int         N          = 4;
    localparam logic [1:0] BAUD_9600  = 2'd0;
    localparam logic [1:0] BAUD_19200 = 2'd1;

    typedef struct {
        int         lane;
        logic [7:0] data;
    } exp_t;

    logic           clk_src = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [1:0]     cfg_baud_rate;
    logic           cfg_update;
    logic [1:0]     baud_rate;
    logic           clk_gen_reset;
    logic           cfg_pending;
    logic [1:0]     grant;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   pushed = 0;
    int   ready_cnt = 0;
    int   cyc = 0;
    int   busy_left = 0;
    int   busy_len = 20;
    bit   model_en = 1'b1;

    uart_8n1_tx_scheduler #(.N(N), .GEN_RESET_CYCLES(2)) dut (
        .clk_src      (clk_src),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
`ifdef UART_8N1_TX_SCHED_LOCK_EN
        .req_lock     (req_lock),
`endif
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .cfg_baud_rate(cfg_baud_rate),
        .cfg_update   (cfg_update),
        .baud_rate    (baud_rate),
        .clk_gen_reset(clk_gen_reset),
        .cfg_pending  (cfg_pending),
        .grant        (grant)
    );

    always #5 clk_src = ~clk_src;
    always @(posedge clk_src) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int lane, input logic [7:0] data);
        exp_t e;
        e.lane = lane;
        e.data = data;
        sb_q.push_back(e);
        pushed++;
    endtask

    task automatic tick();
        @(posedge clk_src);
        #3;
    endtask

    task automatic wait_drain(input string name, input int keep);
        int n = 0;
        while (sb_q.size() > keep && n < 400) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, sb_q.size(), keep);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((tx_busy || tx_start) && n < 200) begin
            tick();
            n++;
        end
        check("quiet_timeout", (n < 200), 1);
        repeat (5) tick();
    endtask

    // Transmitter model: answers tx_start with busy_len cycles of tx_busy, changing 1 time unit after the edge.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk_src);
            #1;
            if (tx_busy) begin
                busy_left--;
                if (busy_left == 0) tx_busy = 1'b0;
            end else if (model_en && tx_start) begin
                tx_busy   = 1'b1;
                busy_left = busy_len;
            end
        end
    end

    always @(negedge clk_src) begin
        if (req_ready !== '0) begin
            exp_t e;
            ready_cnt++;
            check("ready_onehot", $onehot(req_ready), 1);
            check("ready_during_gen_reset", clk_gen_reset, 0);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_accept actual=%b required=none (cycle %0d)", req_ready, cyc);
            end else begin
                e = sb_q.pop_front();
                check("ready_lane", req_ready, 32'(1) << e.lane);
                check("tx_data", tx_data, e.data);
                check("grant", grant, e.lane);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rise, t_fall, t_drop, t_acc, n, hi, rises;
        logic prev_gr;
        reset         = 1'b1;
        req_valid     = '0;
        req_data      = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req_lock      = '0;
        cfg_baud_rate = BAUD_9600;
        cfg_update    = 1'b0;
        repeat (3) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_gen_reset", clk_gen_reset, 0);
        check("rst_baud", baud_rate, BAUD_9600);
        check("rst_cfg_pending", cfg_pending, 0);
        check("rst_grant", grant, N - 1);
        reset = 1'b0;
        tick();

        // Lanes 0 and 2 held valid: round robin alternates 0,2,0,2.
        push(0, 8'hA0); push(2, 8'hC2); push(0, 8'hA0); push(2, 8'hC2);
        req_valid = 4'b0101;
        wait_drain("rr", 0);
        req_valid = '0;
        wait_quiet();
        check("rr_pulses", ready_cnt, 4);
        check("rr_last_grant", grant, 2);

        // Single byte on lane 3: start/busy handshake timing.
        req_data[31:24] = 8'hA5;
        push(3, 8'hA5);
        req_valid = 4'b1000;
        tick();
        check("lane3_ready", req_ready, 4'b1000);
        check("start_low_at_accept", tx_start, 0);
        req_valid = '0;
        tick();
        check("start_high", tx_start, 1);
        check("start_data", tx_data, 8'hA5);
        n = 0;
        while (!tx_busy && n < 50) begin tick(); n++; end
        check("busy_rise_timeout", tx_busy, 1);
        t_rise = cyc;
        n = 0;
        while (tx_start && n < 50) begin tick(); n++; end
        t_fall = cyc;
        check("start_fall_delay", t_fall - t_rise, 3);
        push(0, 8'hA0);
        req_valid = 4'b0001;
        n = 0;
        while (tx_busy && n < 100) begin
            check("no_accept_in_frame", req_ready, 0);
            tick();
            n++;
        end
        t_drop = cyc;
        n = 0;
        while (req_ready == '0 && n < 50) begin tick(); n++; end
        t_acc = cyc;
        // tx_busy is first sampled low at edge t_drop+1.
        check("next_accept_delay", t_acc - (t_drop + 1), 3);
        req_valid = '0;
        wait_quiet();

        // Baud change requested mid-frame, lane 2 waiting behind it.
        push(1, 8'hB1);
        req_valid = 4'b0010;
        wait_drain("cfg_a", 0);
        push(2, 8'hC2);
        req_valid = 4'b0100;
        n = 0;
        while (!tx_busy && n < 50) begin tick(); n++; end
        repeat (4) tick();
        cfg_baud_rate = BAUD_19200;
        cfg_update    = 1'b1;
        tick();
        cfg_update = 1'b0;
        check("cfg_pending_set", cfg_pending, 1);
        n = 0;
        while (!clk_gen_reset && n < 100) begin
            check("baud_held_mid_frame", baud_rate, BAUD_9600);
            tick();
            n++;
        end
        check("gen_reset_seen", clk_gen_reset, 1);
        check("reconf_after_drain", tx_busy, 0);
        check("baud_applied_19200", baud_rate, BAUD_19200);
        check("cfg_pending_cleared", cfg_pending, 0);
        check("lane2_still_waiting", sb_q.size(), 1);
        hi = 0;
        while (clk_gen_reset && hi < 20) begin
            check("no_ready_in_gen_reset", req_ready, 0);
            hi++;
            tick();
        end
        check("gen_reset_len", hi, 2);
        wait_drain("cfg_b", 0);
        req_valid = '0;
        wait_quiet();

        // Two strobes before the frame ends: one RECONF with the last value.
        push(3, 8'hA5);
        req_valid = 4'b1000;
        wait_drain("dbl_a", 0);
        req_valid = '0;
        n = 0;
        while (!tx_busy && n < 50) begin tick(); n++; end
        cfg_baud_rate = BAUD_19200; cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        repeat (3) tick();
        cfg_baud_rate = BAUD_9600; cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        check("dbl_pending", cfg_pending, 1);
        n = 0;
        while (!clk_gen_reset && n < 100) begin
            check("dbl_baud_held", baud_rate, BAUD_19200);
            tick();
            n++;
        end
        check("dbl_baud_9600", baud_rate, BAUD_9600);
        rises = 0;
        prev_gr = 1'b1;
        repeat (15) begin
            tick();
            if (clk_gen_reset && !prev_gr) rises++;
            prev_gr = clk_gen_reset;
        end
        check("dbl_single_reconf", rises, 0);
        check("dbl_pending_clear", cfg_pending, 0);

        // Reset while in START: byte dropped, round robin restarts from lane 0.
        model_en = 1'b0;
        push(1, 8'hB1);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        check("in_start", tx_start, 1);
        reset = 1'b1;
        tick();
        check("rst_mid_start", tx_start, 0);
        check("rst_mid_grant", grant, N - 1);
        check("rst_mid_ready", req_ready, 0);
        reset    = 1'b0;
        model_en = 1'b1;
        push(0, 8'hA0); push(1, 8'hB1);
        req_valid = 4'b0011;
        wait_drain("post_rst", 0);
        req_valid = '0;
        wait_quiet();

`ifdef UART_8N1_TX_SCHED_LOCK_EN
        // Lane 1 locked: re-granted three times, lane 2 follows once the lock drops.
        push(1, 8'hB1); push(1, 8'hB1); push(1, 8'hB1); push(2, 8'hC2);
        req_lock  = 4'b0010;
        req_valid = 4'b0110;
        wait_drain("lock_a", 1);
        req_lock = '0;
        wait_drain("lock_b", 0);
        req_valid = '0;
        wait_quiet();
`endif

        check("sb_empty", sb_q.size(), 0);
        check("pulse_total", ready_cnt, pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
